recip_div_finalize: RTL



---
 rtl/div_pkg.sv | 24 ++
 rtl/recip_div_finalize_if.sv | 28 ++
 rtl/shift_add_mul.sv | 53 +++++
 rtl/recip_div_finalize.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the Q5.19 reciprocal unit
// and the divide finalizer that consumes it.
package div_pkg;

    localparam int W    = 16;
    localparam int FRAC = 19;
    localparam int RW   = 24;
    localparam int AW   = W + RW;
    localparam int PW   = 2 * W;
    localparam int XW   = PW + 1;
    localparam int QW   = AW - FRAC;

    typedef logic [4:-19] q5_19_t;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        PROD,
        CHK,
        CORR,
        DONE
    } state_t;

endpackage

// File: rtl/recip_div_finalize_if.sv
// Operand/result handshake bundle for the divide finalizer.
// The producer/consumer side uses master; the divider uses slave.
interface recip_div_finalize_if;
    import div_pkg::*;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] numer;
    logic [W-1:0] denom;
    q5_19_t       recip;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quot;
    logic [W-1:0] rem;
    logic         div_zero;
    logic         approx_err;

    modport master (
        output in_valid, numer, denom, recip, out_ready,
        input  in_ready, out_valid, quot, rem, div_zero, approx_err
    );

    modport slave (
        input  in_valid, numer, denom, recip, out_ready,
        output in_ready, out_valid, quot, rem, div_zero, approx_err
    );

endinterface

// File: rtl/shift_add_mul.sv
// Unsigned sequential shift-add multiplier: start loads the operands,
// one multiplier bit per cycle, done flags the cycle of the last step.
module shift_add_mul #(
    parameter int AW = 16,
    parameter int BW = 24,
    parameter int PW = AW + BW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] a,
    input  logic [BW-1:0] b,
    output logic          done,
    output logic [PW-1:0] prod
);

    localparam int CW = $clog2(AW);

    logic [AW-1:0] a_q;
    logic [PW-1:0] b_q;
    logic [CW-1:0] cnt;
    logic          busy;

    assign done = busy && (cnt == CW'(AW - 1));

    // b_q tracks b << cnt, a_q exposes multiplier bit cnt at bit 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
            a_q  <= '0;
            b_q  <= '0;
            prod <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            a_q  <= a;
            b_q  <= PW'(b);
            prod <= '0;
        end else if (busy) begin
            if (a_q[0]) begin
                prod <= prod + b_q;
            end
            a_q <= a_q >> 1;
            b_q <= b_q << 1;
            cnt <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/recip_div_finalize.sv
// Turns N, D and a Q5.19 reciprocal of D into an exact quotient and
// remainder: q = N*R >> FRAC, then a q*D pass corrects q by one.
module recip_div_finalize
    import div_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    recip_div_finalize_if.slave bus
);

    localparam int QMAX = (1 << W) - 1;

    state_t state, state_n;

    logic [W-1:0]  n_q, d_q, q_q;
    logic [W-1:0]  quot_r, quot_n;
    logic [W-1:0]  rem_r, rem_n;
    logic          dz_r, dz_n;
    logic          ae_r, ae_n;
    logic          accept;
    logic          m1_start, m1_done;
    logic          m2_start, m2_done;
    logic [AW-1:0] m1_prod;
    logic [PW-1:0] m2_prod;
    logic [QW-1:0] qraw;
    logic [W-1:0]  qsat;

    logic signed [XW-1:0] r0, dext, rc;
    logic [W-1:0]         qc;
    logic                 corr_err;

    assign bus.in_ready   = (state == IDLE);
    assign bus.out_valid  = (state == DONE);
    assign bus.quot       = quot_r;
    assign bus.rem        = rem_r;
    assign bus.div_zero   = dz_r;
    assign bus.approx_err = ae_r;

    assign accept   = bus.in_valid && bus.in_ready;
    assign m1_start = accept && (bus.denom != '0);
    assign m2_start = (state == PROD);

    shift_add_mul #(
        .AW (W),
        .BW (RW),
        .PW (AW)
    ) u_mul_nr (
        .clk   (clk),
        .rst   (rst),
        .start (m1_start),
        .a     (bus.numer),
        .b     (bus.recip),
        .done  (m1_done),
        .prod  (m1_prod)
    );

    shift_add_mul #(
        .AW (W),
        .BW (W),
        .PW (PW)
    ) u_mul_qd (
        .clk   (clk),
        .rst   (rst),
        .start (m2_start),
        .a     (qsat),
        .b     (d_q),
        .done  (m2_done),
        .prod  (m2_prod)
    );

    assign qraw = QW'(m1_prod >> FRAC);
    assign qsat = (qraw > QW'(QMAX)) ? '1 : qraw[W-1:0];

    assign r0   = $signed(XW'(n_q)) - $signed(XW'(m2_prod));
    assign dext = $signed(XW'(d_q));

    // A q already at all-ones cannot step up; it is flagged instead
    always_comb begin
        qc       = q_q;
        rc       = r0;
        corr_err = 1'b0;
        if (r0 < 0) begin
            qc = q_q - 1'b1;
            rc = r0 + dext;
        end else if (r0 >= dext) begin
            if (&q_q) begin
                corr_err = 1'b1;
            end else begin
                qc = q_q + 1'b1;
                rc = r0 - dext;
            end
        end
        if ((rc < 0) || (rc >= dext)) begin
            corr_err = 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        quot_n  = quot_r;
        rem_n   = rem_r;
        dz_n    = dz_r;
        ae_n    = ae_r;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = MUL;
                    dz_n    = 1'b0;
                    ae_n    = 1'b0;
                end
            end
            MUL: begin
                if (d_q == '0) begin
                    state_n = DONE;
                    quot_n  = '1;
                    rem_n   = n_q;
                    dz_n    = 1'b1;
                end else if (m1_done) begin
                    state_n = PROD;
                end
            end
            PROD: begin
                state_n = CHK;
            end
            CHK: begin
                if (m2_done) begin
                    state_n = CORR;
                end
            end
            CORR: begin
                state_n = DONE;
                quot_n  = qc;
                rem_n   = rc[W-1:0];
                ae_n    = corr_err;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            n_q    <= '0;
            d_q    <= '0;
            q_q    <= '0;
            quot_r <= '0;
            rem_r  <= '0;
            dz_r   <= 1'b0;
            ae_r   <= 1'b0;
        end else begin
            state  <= state_n;
            quot_r <= quot_n;
            rem_r  <= rem_n;
            dz_r   <= dz_n;
            ae_r   <= ae_n;
            if (accept) begin
                n_q <= bus.numer;
                d_q <= bus.denom;
            end
            if (state == PROD) begin
                q_q <= qsat;
            end
        end
    end

endmodule
